// File: rtl/debug_inst_loader_pkg.sv
// Shared definitions for the debug instruction loader.
// Provides the command byte values, the HALT word, the FSM state
// encoding, default widths and a small helper for HALT detection.
package debug_inst_loader_pkg;

  localparam int DEFAULT_PC_BITS  = 8;
  localparam int INSTRUCTION_BITS = 32;

  localparam logic [7:0]  CMD_LOAD  = 8'h01;
  localparam logic [7:0]  CMD_RUN   = 8'h02;
  localparam logic [7:0]  CMD_STEP  = 8'h03;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_STEP  = 3'd4
  } state_e;

  function automatic logic is_halt_word(input logic [31:0] word);
    return (word == HALT_WORD);
  endfunction

endpackage

// File: rtl/debug_inst_loader_byte_assembler.sv
// byte_assembler: collects bytes MSB-first into a 32-bit word.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   i_clear       - synchronous clear of count, shift register and strobe
//   i_valid       - i_byte is valid this cycle
//   i_byte        - incoming byte
//   o_word        - registered assembled word
//   o_word_valid  - one-cycle strobe, high the cycle after the 4th byte
module byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  count_q;
  logic [31:0] shift_q;
  logic        word_valid_q;

  // Shift bytes in and flag completion after the fourth one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= 2'd0;
      shift_q      <= 32'd0;
      word_valid_q <= 1'b0;
    end else if (i_clear) begin
      count_q      <= 2'd0;
      shift_q      <= 32'd0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= i_valid && (count_q == 2'd3);
      if (i_valid) begin
        shift_q <= {shift_q[23:0], i_byte};
        // Counter wraps 3 -> 0 naturally, starting the next word.
        count_q <= count_q + 2'd1;
      end
    end
  end

  assign o_word       = shift_q;
  assign o_word_valid = word_valid_q;

endmodule

// File: rtl/debug_inst_loader.sv
// debug_inst_loader: loads a program from a UART byte stream into
// instruction memory, then gates the pipeline in run or single-step mode.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   i_rx_data/valid   - received byte and its one-cycle strobe
//   i_halt            - pipeline retired HALT (only honoured in RUN)
//   o_write_inst_mem  - one-cycle instruction-memory write strobe
//   o_inst_mem_addr   - write address
//   o_inst_mem_data   - write data
//   o_enable          - pipeline advance enable
//   o_loaded          - a complete program has been loaded since reset
module debug_inst_loader
  import debug_inst_loader_pkg::*;
#(
  parameter int PC_BITS          = DEFAULT_PC_BITS,
  parameter int INSTRUCTION_BITS = debug_inst_loader_pkg::INSTRUCTION_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  input  logic                        i_halt,
  output logic                        o_write_inst_mem,
  output logic [PC_BITS-1:0]          o_inst_mem_addr,
  output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
  output logic                        o_enable,
  output logic                        o_loaded
);

  localparam logic [PC_BITS-1:0] ADDR_MAX = '1;
  localparam logic [PC_BITS-1:0] ADDR_ONE = {{(PC_BITS-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [PC_BITS-1:0] addr_q, addr_d;
  logic               loaded_q, loaded_d;
  logic               enable_q;
  logic               clear_s;
  logic               asm_valid_s;
  logic [31:0]        word_s;
  logic               word_valid_s;
  logic               final_s;

  // Only bytes received while loading are data; everything else is a command.
  assign asm_valid_s = i_rx_valid && (state_q == ST_LOAD);

  byte_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (clear_s),
    .i_valid      (asm_valid_s),
    .i_byte       (i_rx_data),
    .o_word       (word_s),
    .o_word_valid (word_valid_s)
  );

  // The write in progress ends the load: HALT word or last memory slot.
  assign final_s = word_valid_s && (is_halt_word(word_s) || (addr_q == ADDR_MAX));

  // Next-state, address and loaded-flag logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    loaded_d = loaded_q;
    clear_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid && (i_rx_data == CMD_LOAD)) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          clear_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (final_s) begin
          state_d  = ST_READY;
          loaded_d = 1'b1;
        end else if (word_valid_s) begin
          addr_d = addr_q + ADDR_ONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_READY: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d = ST_LOAD;
              addr_d  = '0;
              clear_s = 1'b1;
            end
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            default:  state_d = ST_READY;
          endcase
        end else begin
          state_d = ST_READY;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: state_d = ST_READY;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, address, loaded flag and registered enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      loaded_q <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      loaded_q <= loaded_d;
      // Enable follows the state being entered, so it rises the cycle
      // after a command and a STEP yields exactly one cycle.
      enable_q <= (state_d == ST_RUN) || (state_d == ST_STEP);
    end
  end

  assign o_write_inst_mem = word_valid_s;
  assign o_inst_mem_addr  = addr_q;
  assign o_inst_mem_data  = word_s;
  assign o_enable         = enable_q;
  // Loaded is visible already in the cycle of the final write strobe.
  assign o_loaded         = loaded_q || final_s;

endmodule

// File: tb/tb_debug_inst_loader.sv
module tb_debug_inst_loader;

  localparam int PCA = 8;
  localparam int PCB = 3;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] rxd_a, rxd_b;
  logic rxv_a, rxv_b, halt_a, halt_b;
  logic we_a, we_b, en_a, en_b, ld_a, ld_b;
  logic [PCA-1:0] addr_a;
  logic [PCB-1:0] addr_b;
  logic [31:0] data_a, data_b;

  always #5 clk = ~clk;

  debug_inst_loader #(.PC_BITS(PCA), .INSTRUCTION_BITS(32)) dut_a (
    .clk(clk), .rst(rst), .i_rx_data(rxd_a), .i_rx_valid(rxv_a), .i_halt(halt_a),
    .o_write_inst_mem(we_a), .o_inst_mem_addr(addr_a), .o_inst_mem_data(data_a),
    .o_enable(en_a), .o_loaded(ld_a));

  debug_inst_loader #(.PC_BITS(PCB), .INSTRUCTION_BITS(32)) dut_b (
    .clk(clk), .rst(rst), .i_rx_data(rxd_b), .i_rx_valid(rxv_b), .i_halt(halt_b),
    .o_write_inst_mem(we_b), .o_inst_mem_addr(addr_b), .o_inst_mem_data(data_b),
    .o_enable(en_b), .o_loaded(ld_b));

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    bit          fin;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];
  bit  exp_loaded_a, exp_loaded_b;
  int  en_cnt_a, en_cnt_b, wr_cnt_a, wr_cnt_b;
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference model: a load of 'words' writes consecutive addresses from 0
  // and stops after the HALT word or after the last address of memory.
  function automatic int plan_load(input int which, input int pc_bits, input logic [31:0] words[$]);
    int n = 0;
    for (int i = 0; i < words.size(); i++) begin
      wr_t e;
      e.addr = 8'(i);
      e.data = words[i];
      e.fin  = (words[i] == HALT) || (i == (1 << pc_bits) - 1);
      if (which == 0) exp_a.push_back(e); else exp_b.push_back(e);
      n++;
      if (e.fin) break;
    end
    return n;
  endfunction

  // Write-port monitor for both instances.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst) begin
      if (en_a) en_cnt_a++;
      if (en_b) en_cnt_b++;
      if (we_a) begin
        wr_cnt_a++;
        check("a_enable_during_write", en_a, 0);
        check("a_write_expected", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) begin
          e = exp_a.pop_front();
          if (e.fin) exp_loaded_a = 1'b1;
          check("a_addr", addr_a, e.addr);
          check("a_data", data_a, e.data);
          check("a_loaded_at_write", ld_a, exp_loaded_a);
        end
      end
      if (we_b) begin
        wr_cnt_b++;
        check("b_enable_during_write", en_b, 0);
        check("b_write_expected", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) begin
          e = exp_b.pop_front();
          if (e.fin) exp_loaded_b = 1'b1;
          check("b_addr", addr_b, e.addr[PCB-1:0]);
          check("b_data", data_b, e.data);
          check("b_loaded_at_write", ld_b, exp_loaded_b);
        end
      end
    end
  end

  // Caller is at a negedge; byte is valid for exactly one cycle.
  task automatic send_byte(input int which, input logic [7:0] b);
    if (which == 0) begin rxd_a = b; rxv_a = 1'b1; end
    else begin rxd_b = b; rxv_b = 1'b1; end
    @(negedge clk);
    rxv_a = 1'b0;
    rxv_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_word(input int which, input logic [31:0] w, input bit gaps);
    logic [31:0] v;
    v = w;
    for (int k = 3; k >= 0; k--) begin
      send_byte(which, v[k*8 +: 8]);
      if (gaps && ($urandom_range(0, 1) == 1)) @(negedge clk);
    end
  endtask

  task automatic load(input int which, input int pc_bits, input logic [31:0] words[$], input bit gaps);
    int n;
    send_byte(which, 8'h01);
    n = plan_load(which, pc_bits, words);
    for (int i = 0; i < n; i++) send_word(which, words[i], gaps);
    idle(6);
  endtask

  initial begin
    logic [31:0] words[$];
    int base, nrun;
    rst = 1'b0;
    rxd_a = 8'h00; rxd_b = 8'h00; rxv_a = 1'b0; rxv_b = 1'b0;
    halt_a = 1'b0; halt_b = 1'b0;
    exp_loaded_a = 1'b0; exp_loaded_b = 1'b0;
    en_cnt_a = 0; en_cnt_b = 0; wr_cnt_a = 0; wr_cnt_b = 0;
    idle(3);
    check("rst_we", we_a, 0);
    check("rst_en", en_a, 0);
    check("rst_loaded", ld_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_data", data_a, 0);
    check("rst_b_loaded", ld_b, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Non-LOAD bytes in IDLE do nothing.
    halt_a = 1'b1;
    send_byte(0, 8'h02); send_byte(0, 8'h03); send_byte(0, 8'h7F);
    for (int i = 0; i < 5; i++) send_byte(0, 8'($urandom_range(2, 255)));
    halt_a = 1'b0;
    idle(3);
    check("idle_no_enable", en_cnt_a, 0);
    check("idle_no_write", wr_cnt_a, 0);
    check("idle_not_loaded", ld_a, 0);

    // Directed program load.
    words = '{32'h1234_5678, 32'hABCD_EF01, HALT};
    load(0, PCA, words, 1'b0);
    check("load1_writes", wr_cnt_a, 3);
    check("load1_pending", exp_a.size(), 0);
    check("load1_loaded", ld_a, 1);
    check("load1_no_enable", en_cnt_a, 0);

    // Two single steps; HALT high during a step must not matter.
    base = en_cnt_a;
    halt_a = 1'b1;
    send_byte(0, 8'h03);
    check("step1_en_high", en_a, 1);
    @(negedge clk);
    check("step1_en_low", en_a, 0);
    halt_a = 1'b0;
    idle(2);
    send_byte(0, 8'h03);
    check("step2_en_high", en_a, 1);
    idle(3);
    check("step_pulse_count", en_cnt_a - base, 2);

    // Run until HALT, ignoring bytes while running; then run again.
    send_byte(0, 8'h02);
    check("run_en_rise", en_a, 1);
    send_byte(0, 8'h01);
    nrun = $urandom_range(3, 10);
    idle(nrun);
    check("run_en_held", en_a, 1);
    check("run_no_write", exp_a.size(), 0);
    halt_a = 1'b1;
    @(negedge clk);
    check("run_halt_drop", en_a, 0);
    halt_a = 1'b0;
    idle(2);
    check("ready_en_low", en_a, 0);
    send_byte(0, 8'h02);
    check("rerun_en", en_a, 1);
    idle(2);
    halt_a = 1'b1;
    @(negedge clk);
    check("rerun_halt_drop", en_a, 0);
    halt_a = 1'b0;
    idle(2);

    // Randomized reloads from READY, back-to-back or gapped bytes.
    for (int r = 0; r < 4; r++) begin
      words.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) words.push_back($urandom());
      words.push_back(HALT);
      base = wr_cnt_a;
      load(0, PCA, words, r[0]);
      check("rand_pending", exp_a.size(), 0);
      check("rand_loaded", ld_a, 1);
      check("rand_no_enable", en_a, 0);
    end

    // Small memory: eight non-HALT words fill it and end the load.
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back($urandom() & 32'h7FFF_FFFF);
    load(1, PCB, words, 1'b1);
    check("full_writes", wr_cnt_b, 8);
    check("full_pending", exp_b.size(), 0);
    check("full_loaded", ld_b, 1);
    base = wr_cnt_b;
    send_byte(1, 8'h55); send_byte(1, 8'h66); send_byte(1, 8'h77); send_byte(1, 8'h88);
    idle(4);
    check("full_no_more_writes", wr_cnt_b - base, 0);
    send_byte(1, 8'h03);
    check("full_ready_step", en_b, 1);
    idle(2);

    // Reset in the middle of a word, then reload cleanly.
    send_byte(0, 8'h01); send_byte(0, 8'h12); send_byte(0, 8'h34);
    #3 rst = 1'b0;
    #1;
    check("midrst_we", we_a, 0);
    check("midrst_loaded", ld_a, 0);
    check("midrst_addr", addr_a, 0);
    check("midrst_data", data_a, 0);
    check("midrst_b_loaded", ld_b, 0);
    exp_loaded_a = 1'b0; exp_loaded_b = 1'b0;
    exp_a.delete(); exp_b.delete();
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    base = wr_cnt_a;
    words = '{32'hCAFE_BABE, HALT};
    load(0, PCA, words, 1'b0);
    check("reload_writes", wr_cnt_a - base, 2);
    check("reload_pending", exp_a.size(), 0);
    check("reload_loaded", ld_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_inst_loader.md
# debug_inst_loader

Debug-side control block that sits directly upstream of the instruction fetch stage. It receives a byte stream from the UART receiver, assembles 32-bit instruction words, and writes them into instruction memory at consecutive addresses. It then gates the pipeline through a global enable, in either continuous-run or single-step mode. It drives the fetch stage's instruction-memory write port and enable input, and is the only source of those signals.

## Interface
- `PC_BITS`, default `` `PC_BITS ``: width of the instruction-memory address.
- `INSTRUCTION_BITS`, default `` `INSTRUCTION_BITS `` (32): instruction width; fixed at 32 for this block.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_rx_data` in 8: byte from the UART receiver.
- `i_rx_valid` in 1: one-cycle strobe; `i_rx_data` is valid in that cycle.
- `i_halt` in 1: pipeline has retired the HALT instruction (level, sampled each cycle).
- `o_write_inst_mem` out 1: one-cycle instruction-memory write strobe.
- `o_inst_mem_addr` out PC_BITS: write address.
- `o_inst_mem_data` out 32: write data.
- `o_enable` out 1: pipeline advance enable.
- `o_loaded` out 1: a program has been fully loaded since reset.

## Operation
- Command bytes (in `constants.vh`): `CMD_LOAD` = 0x01, `CMD_RUN` = 0x02, `CMD_STEP` = 0x03. Any other byte is ignored where a command is expected.
- `HALT_WORD` = 32'hFFFF_FFFF.
- States:
  - IDLE: reset state. `CMD_LOAD` → LOAD. Other bytes are ignored.
  - LOAD: bytes are assembled MSB-first, four per word. After the 4th byte, the word is written at the current address and the address increments by 1.
    - If the written word == `HALT_WORD`, or the written address == 2^PC_BITS−1 (memory full), → READY and set `o_loaded`.
    - The HALT word itself is written.
  - READY: `CMD_RUN` → RUN. `CMD_STEP` → STEP. `CMD_LOAD` → LOAD, restarting at address 0 with the byte count cleared; `o_loaded` stays 1.
  - RUN: `o_enable` = 1 continuously. `i_halt` = 1 → READY. All bytes are ignored.
  - STEP: `o_enable` = 1 for exactly one cycle, then → READY unconditionally.
- `o_enable` is 0 in IDLE, LOAD and READY, and is never high in the same cycle as `o_write_inst_mem`.
- `i_halt` is ignored outside RUN.
- Address wrap cannot occur, because LOAD exits at the last address.

## Timing
- Reset (asynchronous, any state, including mid-word or mid-run): state IDLE, byte count 0, address 0, word register 0, all outputs 0.
- Write latency: `o_write_inst_mem` is high in the cycle after the `i_rx_valid` carrying byte 4.
  - `o_inst_mem_addr` and `o_inst_mem_data` are stable and registered in that cycle.
  - The address increments on the following edge.
- A byte strobe in the same cycle as a write strobe is accepted normally and becomes byte 1 of the next word.
- The state transition on a command byte takes effect on the edge that samples `i_rx_valid`. `o_enable` rises in the next cycle.
- STEP: `o_enable` is high for one cycle only, regardless of `i_halt` in that cycle.
- RUN: `i_halt` sampled high → `o_enable` low on the next cycle.
- `o_loaded` rises in the same cycle the final write strobe is driven.

## Structure
- `constants.vh` gains `CMD_LOAD`, `CMD_RUN`, `CMD_STEP`, `HALT_WORD` and the state encodings, next to the existing `PC_BITS` / `INSTRUCTION_BITS`.
- One sub-module: `byte_assembler`.
  - Contents: 2-bit byte counter plus 32-bit shift register.
  - Ports: `clk`, `rst`, `i_clear`, `i_valid`, `i_byte`; outputs `o_word`, `o_word_valid` (one-cycle).
- The top level holds the FSM, the address counter and the output registers.

## Test plan
- Reset, then 0x01 followed by bytes 12 34 56 78 AB CD EF 01 FF FF FF FF.
  - Required: write strobes at addr 0 = 0x12345678, addr 1 = 0xABCDEF01, addr 2 = 0xFFFFFFFF.
  - `o_loaded` = 1; `o_enable` stays 0 throughout.
- After load, send 0x03 twice (≥2 cycles apart): exactly two single-cycle `o_enable` pulses.
- After load, send 0x02: `o_enable` stays high; assert `i_halt` → `o_enable` low on the next cycle.
  - A further 0x02 re-enters RUN.
- PC_BITS = 3, send 8 non-HALT words: 8 writes at addr 0–7, then READY. Further bytes produce no write.
- Assert `rst` after 2 bytes of a word, then reload: first write lands at addr 0 with a clean 4-byte word.
- In IDLE send 0x02, 0x03, 0x7F: no state change, `o_enable` = 0, no writes.
